// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding, funct codes and iteration count for the HI/LO multiply unit.
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam int ITERS = 32;
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage strobes, operands and HI/LO result/stall between decoder and mdu_hilo.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             multiply;
    logic [5:0]       funct;
    logic             mfhi;
    logic             mflo;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             stall;
    modport master (output multiply, funct, mfhi, mflo, srca, srcb, input hilo_out, busy, stall);
    modport slave (input multiply, funct, mfhi, mflo, srca, srcb, output hilo_out, busy, stall);
endinterface

// File: rtl/mdu_datapath.sv
// mdu_datapath: shift/add multiply step on magnitudes plus final sign fix-up.
// With MDU_DIV_EN defined it also performs a restoring divide step on the same accumulator.
module mdu_datapath import mdu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
`ifdef MDU_DIV_EN
    input  logic               is_div,
`endif
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0]   mcand, a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic               neg;
    assign a_mag = sgn && a[WIDTH-1] ? -a : a;
    assign b_mag = sgn && b[WIDTH-1] ? -b : b;
    // carry out of the upper-half add shifts straight into the MSB
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : WIDTH'(0)};
`ifdef MDU_DIV_EN
    logic           div_q, neg_rem;
    logic [WIDTH:0] rem_sh, diff;
    assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mcand};
    assign acc_nx = div_q ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]}
                          : {sum, acc[WIDTH-1:1]};
    assign result = div_q ? {neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                             neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
                          : (neg ? -acc : acc);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            div_q   <= 1'b0;
            neg_rem <= 1'b0;
        end else if (load) begin
            div_q   <= is_div;
            neg_rem <= sgn && a[WIDTH-1];
        end
`else
    assign acc_nx = {sum, acc[WIDTH-1:1]};
    assign result = neg ? -acc : acc;
`endif
    // divide by zero keeps the quotient all ones by never negating it
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
        end else if (load) begin
`ifdef MDU_DIV_EN
            mcand <= is_div ? b_mag : a_mag;
            acc   <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && !(is_div && b == '0);
`else
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end else if (step)
            acc <= acc_nx;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative mult/multu unit owning HI/LO, stalling EX while an operation is in flight.
// Define MDU_DIV_EN to also accept div/divu on the same 33-cycle schedule.
module mdu_hilo import mdu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);
    localparam int CW = $clog2(ITERS);
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] result;
    logic               is_mul, go, load, step, wr;
    assign is_mul = bus.funct == MULT || bus.funct == MULTU;
`ifdef MDU_DIV_EN
    logic is_div;
    assign is_div = bus.funct == DIV || bus.funct == DIVU;
    assign go     = bus.multiply && (is_mul || is_div);
`else
    assign go     = bus.multiply && is_mul;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (go ? RUN : IDLE) :
                   state == RUN  ? (cnt == CW'(ITERS - 1) ? DONE : RUN) : IDLE;
    always_comb begin
        load = state == IDLE && go;
        step = state == RUN;
        wr   = state == DONE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)     cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt + 1'b1;
    // HI/LO only change in DONE, so reads never see a partial product
    always_ff @(posedge clk or posedge reset)
        if (reset)   {hi, lo} <= '0;
        else if (wr) {hi, lo} <= result;
    assign bus.busy     = state != IDLE;
    assign bus.stall    = bus.busy && (bus.multiply || bus.mfhi || bus.mflo);
    assign bus.hilo_out = bus.mfhi ? hi : bus.mflo ? lo : '0;
    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
`ifdef MDU_DIV_EN
        .is_div (is_div),
`endif
        .sgn    (!bus.funct[0]),
        .a      (bus.srca),
        .b      (bus.srcb),
        .result (result)
    );
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized self-checking bench comparing mdu_hilo with a plain-arithmetic HI/LO model.
module tb_mdu_hilo;
    import mdu_pkg::*;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    mdu_hilo_if #(.WIDTH(32)) bus();
    mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            MULT:    return 64'(sa * sb);
            MULTU:   return 64'(ua * ub);
            DIV:     return b == 0 ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            DIVU:    return b == 0 ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
            default: return '0;
        endcase
    endfunction
    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction
    task automatic start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.multiply = 1'b1;
        bus.funct    = f;
        bus.srca     = a;
        bus.srcb     = b;
        tick();
        bus.multiply = 1'b0;
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
    endtask
    task automatic read_check(input string tag);
        bus.mfhi = 1'b1;
        #1;
        chk({tag, "_mfhi"}, bus.hilo_out, exp_hi);
        chk({tag, "_rd_stall"}, bus.stall, 0);
        bus.mfhi = 1'b0;
        bus.mflo = 1'b1;
        #1;
        chk({tag, "_mflo"}, bus.hilo_out, exp_lo);
        bus.mflo = 1'b0;
    endtask
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] r;
        logic        taken;
        taken = f == MULT || f == MULTU || (DIV_EN && (f == DIV || f == DIVU));
        start(f, a, b);
        if (taken) begin
            wait_idle(n);
            chk({tag, "_busy_cycles"}, n, 33);
            r = model(f, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end else
            chk({tag, "_ignored_busy"}, bus.busy, 0);
        read_check(tag);
    endtask
    initial begin
        int          n;
        logic [63:0] r;
        logic [5:0]  fl [4];
        fl = '{MULT, MULTU, DIV, DIVU};
        bus.multiply = 1'b0;
        bus.funct    = MFHI;
        bus.mfhi     = 1'b0;
        bus.mflo     = 1'b0;
        bus.srca     = '0;
        bus.srcb     = '0;
        repeat (2) tick();
        bus.multiply = 1'b1;
        bus.mfhi     = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_hilo", bus.hilo_out, 0);
        bus.multiply = 1'b0;
        bus.mfhi     = 1'b0;
        bus.funct    = MFLO;
        reset = 1'b0;
        tick();
        run_op("mult_3_m5", MULT, 32'd3, 32'hFFFFFFFB);
        chk("mult_3_m5_hi_const", exp_hi, 32'hFFFFFFFF);
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mult_minmin", MULT, 32'h80000000, 32'h80000000);
        run_op("bad_funct", 6'b100000, 32'd7, 32'd9);
        bus.mfhi = 1'b1;
        bus.mflo = 1'b1;
        #1;
        chk("hi_wins", bus.hilo_out, exp_hi);
        bus.mfhi = 1'b0;
        bus.mflo = 1'b0;
        // mflo arrives in N+5 and must wait for the new LO
        start(MULT, 32'h12345678, 32'h9ABCDEF0);
        r = model(MULT, 32'h12345678, 32'h9ABCDEF0);
        repeat (4) tick();
        bus.mflo = 1'b1;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            tick();
            n++;
        end
        chk("mflo_stall_cycles", n, 29);
        chk("mflo_new_lo", bus.hilo_out, r[31:0]);
        bus.mflo = 1'b0;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        // reset in N+10 discards the partial result
        start(MULT, 32'd7, 32'd9);
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        exp_hi = '0;
        exp_lo = '0;
        read_check("midrst");
        reset = 1'b0;
        tick();
        run_op("after_rst_2x2", MULT, 32'd2, 32'd2);
        // second multiply held by stall while the first runs
        start(MULT, 32'hFFFF0001, 32'h00020003);
        r = model(MULT, 32'hFFFF0001, 32'h00020003);
        bus.multiply = 1'b1;
        bus.funct    = MULTU;
        bus.srca     = 32'hDEADBEEF;
        bus.srcb     = 32'h0BADF00D;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_stall_cycles", n, 33);
        bus.mflo = 1'b1;
        #1;
        chk("b2b_first_lo", bus.hilo_out, r[31:0]);
        bus.mflo = 1'b0;
        tick();
        bus.multiply = 1'b0;
        wait_idle(n);
        chk("b2b_busy_cycles", n, 33);
        r = model(MULTU, 32'hDEADBEEF, 32'h0BADF00D);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        read_check("b2b_second");
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE);
        run_op("divu_5_0", DIVU, 32'd5, 32'd0);
        run_op("div_neg_0", DIV, 32'hFFFFFFF9, 32'd0);
        for (int i = 0; i < 24; i++)
            run_op("rand", fl[$urandom_range(0, 3)], rnd_op(), rnd_op());
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply unit owning the HI/LO register pair. It sits in the EX stage beside the ALU and acts on the `multiply`, `mfhi` and `mflo` strobes produced by the ALU decoder. A mult/multu runs over 33 cycles into HI/LO, and mfhi/mflo read HI/LO back onto the EX result path. It raises a stall to the hazard unit whenever a new multiply or a HI/LO read would collide with an operation still in progress.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `multiply` in 1: start strobe from the ALU decoder, qualified by `funct`.
- `funct` in 6: instruction funct field; bit 0 = 1 selects unsigned.
- `mfhi` in 1: read-HI strobe from the ALU decoder.
- `mflo` in 1: read-LO strobe from the ALU decoder.
- `srca` in WIDTH: rs operand.
- `srcb` in WIDTH: rt operand.
- `hilo_out` out WIDTH: HI if `mfhi`, else LO if `mflo`, else 0. Combinational.
- `busy` out 1: an operation is in flight.
- `stall` out 1: `busy & (multiply | mfhi | mflo)`. Combinational; drives the hazard unit.

## Operation
- States:
  - IDLE: accepts a start.
  - RUN: 32 iterations, counter 0..31.
  - DONE: sign fix-up and HI/LO write.
- IDLE -> RUN on `multiply` with `funct` = 011000 (mult) or 011001 (multu).
  - Latch operand magnitudes and the result sign: `srca[31]^srcb[31]` for signed, 0 for unsigned.
  - Clear the 2*WIDTH product accumulator.
- RUN, one bit per cycle, LSB first: if the multiplier bit is set, add the multiplicand to the upper half; shift right by one. Go to DONE after counter = 31.
- DONE: two's-complement negate the 64-bit product if the sign flag is set. Write HI = [63:32], LO = [31:0]. Go to IDLE.
- `busy` is high in RUN and DONE.
- Start while busy: not accepted. `stall` holds the instruction in EX; it is accepted in the first IDLE cycle.
- `multiply` with any funct other than those listed: ignored, no state change.
- `mfhi` and `mflo` both high: HI wins. The decoder never produces this.
- Arithmetic is modulo 2^64. Signed -2^31 * -2^31 gives HI = 0x40000000, LO = 0.
- Reset, including mid-operation: state = IDLE, HI = LO = 0, accumulator and counter = 0, `busy` = 0. The partial result is discarded.

## Timing
- `multiply` accepted in cycle N.
- RUN occupies cycles N+1..N+32, DONE is cycle N+33, and HI/LO update at the end of N+33.
- First non-stalled mfhi/mflo is in cycle N+34 and returns the new value.
- Back-to-back: a second multiply is accepted in cycle N+34.
- `hilo_out`, `busy` and `stall` are zero from reset assertion.
- `hilo_out` never shows a partial product.

## Configuration
- `MDU_DIV_EN` defined: funct 011010 (div) and 011011 (divu) also start the unit.
  - 32-cycle restoring division, then DONE.
  - LO = quotient, truncated toward zero. HI = remainder, carrying the dividend's sign.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
  - Latency is identical to multiply.
- `MDU_DIV_EN` undefined: div/divu starts are ignored and no divider logic is built.

## Structure
- Package `mdu_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - funct constants MULT, MULTU, DIV, DIVU, MFHI, MFLO;
  - the iteration-count constant.
- Sub-module `mdu_datapath`: accumulator, shift/add (and subtract under `MDU_DIV_EN`) step, and final negation. The top level holds the FSM, counter, HI/LO and stall logic.

## Test plan
- mult 3 * 0xFFFFFFFB (-5) -> `busy` for 33 cycles; then mfhi = 0xFFFFFFFF, mflo = 0xFFFFFFF1.
- multu 0xFFFFFFFF * 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- mflo issued in cycle N+5 after a start -> `stall` high through N+33. In N+34, `stall` = 0 and `hilo_out` = the new LO, never the old value.
- `reset` pulsed in cycle N+10 of a mult -> `busy` = 0 immediately and HI = LO = 0. A following mult 2 * 2 gives LO = 4.
- Second mult presented during RUN -> held by `stall`, starts in cycle N+34, completes correctly.
- `MDU_DIV_EN`:
  - div 7 / 0xFFFFFFFE (-2) -> LO = 0xFFFFFFFD, HI = 1.
  - divu 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
  - Without the macro, the same div leaves HI/LO unchanged and `busy` = 0.
